pc_fetch_ctrl: RTL and testbench

Sequencer for the fetch stage. It owns the program counter register and drives the instruction-memory request/acknowledge handshake. It chooses the next PC from four sources: sequential PC+4, ID-stage jump, EX-stage branch redirect and trap vector. It sits between the hazard unit, the ID/EX redirect sources and the IF/ID pipeline register, and it generates the fetch-valid and flush controls.

---
 rtl/pc_fetch_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Fetch-stage sequencer. Owns the program counter, drives the instruction
// memory request/acknowledge handshake and selects the next PC from four
// sources: sequential PC+4, ID-stage jump, EX-stage branch and trap vector.
//
// Redirect priority within one cycle is trap > branch > jump > sequential.
// A redirect that arrives while a fetch is outstanding is remembered as a
// pending target, and the returning instruction is discarded.
//
// Optional build macro: PC_MISALIGN_TRAP_EN
//   defined     : a branch/jump target with bits[1:0] != 0 becomes a trap
//   not defined : branch/jump target bits[1:0] are cleared before loading
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   synchronous reset, active-low
//   stall_i        in   IF/ID cannot accept an instruction this cycle
//   br_valid_i     in   EX-stage branch taken (1-cycle pulse)
//   br_target_i    in   EX branch target
//   jmp_valid_i    in   ID-stage jump (1-cycle pulse)
//   jmp_target_i   in   ID jump target
//   trap_i         in   trap request (1-cycle pulse)
//   imem_req_o     out  instruction fetch request
//   imem_addr_o    out  fetch address
//   imem_ack_i     in   fetch complete, data valid this cycle
//   if_valid_o     out  fetched instruction valid toward IF/ID
//   if_pc_o        out  PC of the instruction on if_valid_o
//   if_pc_plus4_o  out  if_pc_o + 4, modulo 2^32
//   flush_o        out  kill younger instructions (redirect accepted)
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_valid_i,
    input  logic [31:0] br_target_i,
    input  logic        jmp_valid_i,
    input  logic [31:0] jmp_target_i,
    input  logic        trap_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc_plus4_o,
    output logic        flush_o
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Source codes double as ranks: a larger code may override a smaller one.
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_JMP  = 2'd1;
    localparam logic [1:0] SRC_BR   = 2'd2;
    localparam logic [1:0] SRC_TRAP = 2'd3;

    // Clear the byte-offset bits of a branch/jump target.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    logic [1:0]  state_r;
    logic [31:0] pc_r;
    logic [1:0]  pend_src_r;
    logic [31:0] pend_tgt_r;

    logic [1:0]  raw_src_s;
    logic [31:0] raw_tgt_s;
    logic [1:0]  sel_src_s;
    logic [31:0] sel_tgt_s;
    logic        accept_s;
    logic        kill_s;

    logic [1:0]  state_nx_s;
    logic [31:0] pc_nx_s;
    logic [1:0]  pend_src_nx_s;
    logic [31:0] pend_tgt_nx_s;
    logic        req_s;
    logic        valid_s;

    // Pick the highest-priority redirect request of this cycle.
    always_comb begin
        raw_src_s = SRC_NONE;
        raw_tgt_s = 32'h0000_0000;
        if (trap_i) begin
            raw_src_s = SRC_TRAP;
            raw_tgt_s = TRAP_VEC;
        end else if (br_valid_i) begin
            raw_src_s = SRC_BR;
            raw_tgt_s = br_target_i;
        end else if (jmp_valid_i) begin
            raw_src_s = SRC_JMP;
            raw_tgt_s = jmp_target_i;
        end else begin
            raw_src_s = SRC_NONE;
            raw_tgt_s = 32'h0000_0000;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_s;
    // A misaligned branch/jump target is promoted to a trap.
    always_comb begin
        misalign_s = ((raw_src_s == SRC_BR) || (raw_src_s == SRC_JMP)) &&
                     (raw_tgt_s[1:0] != 2'b00);
        if (misalign_s) begin
            sel_src_s = SRC_TRAP;
            sel_tgt_s = TRAP_VEC;
        end else begin
            sel_src_s = raw_src_s;
            sel_tgt_s = raw_tgt_s;
        end
    end
`else
    // Branch/jump targets lose their byte-offset bits; the trap vector is used as-is.
    always_comb begin
        sel_src_s = raw_src_s;
        if (raw_src_s == SRC_TRAP) begin
            sel_tgt_s = raw_tgt_s;
        end else begin
            sel_tgt_s = align_word(raw_tgt_s);
        end
    end
`endif

    // A request is accepted unless a stronger redirect is already pending
    // (a jump is dropped behind a pending branch/trap, a branch behind a trap).
    assign accept_s = (sel_src_s != SRC_NONE) && (sel_src_s >= pend_src_r);
    assign kill_s   = (pend_src_r != SRC_NONE);

    // Next-state, next-PC and pending-redirect logic.
    always_comb begin
        state_nx_s    = state_r;
        pc_nx_s       = pc_r;
        pend_src_nx_s = pend_src_r;
        pend_tgt_nx_s = pend_tgt_r;
        req_s         = 1'b0;
        valid_s       = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_nx_s    = ST_FETCH;
                pend_src_nx_s = SRC_NONE;
                if (accept_s) begin
                    pc_nx_s = sel_tgt_s;
                end else begin
                    pc_nx_s = pc_r;
                end
            end
            ST_FETCH: begin
                req_s = 1'b1;
                if (imem_ack_i) begin
                    pend_src_nx_s = SRC_NONE;
                    if (accept_s || kill_s) begin
                        // Returning instruction is on a dead path.
                        valid_s = 1'b0;
                        pc_nx_s = accept_s ? sel_tgt_s : pend_tgt_r;
                    end else begin
                        valid_s = 1'b1;
                        if (stall_i) begin
                            state_nx_s = ST_HOLD;
                        end else begin
                            pc_nx_s = pc_r + 32'd4;
                        end
                    end
                end else begin
                    // Address must stay fixed; remember the redirect for later.
                    if (accept_s) begin
                        pend_src_nx_s = sel_src_s;
                        pend_tgt_nx_s = sel_tgt_s;
                    end else begin
                        pend_src_nx_s = pend_src_r;
                        pend_tgt_nx_s = pend_tgt_r;
                    end
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    valid_s    = 1'b0;
                    pc_nx_s    = sel_tgt_s;
                    state_nx_s = ST_FETCH;
                end else begin
                    valid_s = 1'b1;
                    if (stall_i) begin
                        state_nx_s = ST_HOLD;
                    end else begin
                        pc_nx_s    = pc_r + 32'd4;
                        state_nx_s = ST_FETCH;
                    end
                end
            end
            default: begin
                // Unreachable encoding: recover through a clean boot.
                state_nx_s    = ST_BOOT;
                pc_nx_s       = RESET_PC;
                pend_src_nx_s = SRC_NONE;
                pend_tgt_nx_s = 32'h0000_0000;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_PC;
            pend_src_r <= SRC_NONE;
            pend_tgt_r <= 32'h0000_0000;
        end else begin
            state_r    <= state_nx_s;
            pc_r       <= pc_nx_s;
            pend_src_r <= pend_src_nx_s;
            pend_tgt_r <= pend_tgt_nx_s;
        end
    end

    // Outputs are forced to their reset values for as long as rst_n is low.
    assign imem_req_o    = rst_n & req_s;
    assign imem_addr_o   = rst_n ? pc_r : RESET_PC;
    assign if_valid_o    = rst_n & valid_s;
    assign if_pc_o       = rst_n ? pc_r : 32'h0000_0000;
    assign if_pc_plus4_o = rst_n ? (pc_r + 32'd4) : 32'h0000_0000;
    assign flush_o       = rst_n & accept_s;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model.
// Honours PC_MISALIGN_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        br_valid_i = 1'b0;
    logic [31:0] br_target_i = 32'h0;
    logic        jmp_valid_i = 1'b0;
    logic [31:0] jmp_target_i = 32'h0;
    logic        trap_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus4_o;
    logic        flush_o;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .br_valid_i   (br_valid_i),
        .br_target_i  (br_target_i),
        .jmp_valid_i  (jmp_valid_i),
        .jmp_target_i (jmp_target_i),
        .trap_i       (trap_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_pc_plus4_o(if_pc_plus4_o),
        .flush_o      (flush_o)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model: "started" = boot cycle done, "holding" = instruction
    // parked in IF waiting for stall to drop, plus an optional remembered redirect.
    bit          m_started;
    bit          m_holding;
    bit          m_pend;
    int          m_pend_rank;
    logic [31:0] m_pc;
    logic [31:0] m_pend_tgt;

    // Last sampled DUT outputs, for directed checks.
    logic        o_req, o_valid, o_flush;
    logic [31:0] o_addr, o_pc, o_plus4;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Redirect source rank (3 trap, 2 branch, 1 jump, 0 none) and its target.
    function automatic void pick(input logic tr, input logic bv, input logic [31:0] bt,
                                 input logic jv, input logic [31:0] jt,
                                 output int rank, output logic [31:0] tgt);
        rank = 0;
        tgt  = 32'h0;
        if (tr) begin
            rank = 3; tgt = TRAP_VEC;
        end else if (bv) begin
            rank = 2; tgt = bt;
        end else if (jv) begin
            rank = 1; tgt = jt;
        end
        if (rank == 1 || rank == 2) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (tgt % 4 != 0) begin
                rank = 3; tgt = TRAP_VEC;
            end
`else
            tgt = tgt - (tgt % 4);
`endif
        end
    endfunction

    // One clock cycle: drive inputs after the falling edge, check, advance model.
    task automatic step(input logic rst, input logic st, input logic ack,
                        input logic tr, input logic bv, input logic [31:0] bt,
                        input logic jv, input logic [31:0] jt);
        int          rank;
        logic [31:0] tgt;
        bit          acc, e_req, e_valid;
        @(negedge clk);
        rst_n = rst; stall_i = st; imem_ack_i = ack; trap_i = tr;
        br_valid_i = bv; br_target_i = bt; jmp_valid_i = jv; jmp_target_i = jt;
        #1;
        o_req = imem_req_o; o_addr = imem_addr_o; o_valid = if_valid_o;
        o_pc = if_pc_o; o_plus4 = if_pc_plus4_o; o_flush = flush_o;
        if (!rst) begin
            check_val("rst_req",   {31'd0, o_req},   32'd0);
            check_val("rst_addr",  o_addr,           RESET_PC);
            check_val("rst_valid", {31'd0, o_valid}, 32'd0);
            check_val("rst_pc",    o_pc,             32'd0);
            check_val("rst_plus4", o_plus4,          32'd0);
            check_val("rst_flush", {31'd0, o_flush}, 32'd0);
            m_started = 0; m_holding = 0; m_pend = 0; m_pend_rank = 0;
            m_pc = RESET_PC; m_pend_tgt = 32'h0;
        end else begin
            pick(tr, bv, bt, jv, jt, rank, tgt);
            acc   = (rank > 0) && (!m_pend || rank >= m_pend_rank);
            e_req = m_started && !m_holding;
            if (!m_started)     e_valid = 0;
            else if (m_holding) e_valid = !acc;
            else                e_valid = ack && !acc && !m_pend;
            check_val("req",   {31'd0, o_req},   {31'd0, e_req});
            check_val("flush", {31'd0, o_flush}, {31'd0, acc});
            check_val("valid", {31'd0, o_valid}, {31'd0, e_valid});
            if (e_req) check_val("addr", o_addr, m_pc);
            if (e_valid) begin
                check_val("if_pc",    o_pc,    m_pc);
                check_val("if_plus4", o_plus4, m_pc + 32'd4);
            end
            // Advance the model to the next cycle.
            if (!m_started) begin
                m_started = 1;
                if (acc) m_pc = tgt;
            end else if (m_holding) begin
                if (acc) begin
                    m_pc = tgt; m_holding = 0;
                end else if (!st) begin
                    m_pc = m_pc + 32'd4; m_holding = 0;
                end
            end else if (ack) begin
                if (acc)         m_pc = tgt;
                else if (m_pend) m_pc = m_pend_tgt;
                else if (st)     m_holding = 1;
                else             m_pc = m_pc + 32'd4;
                m_pend = 0; m_pend_rank = 0;
            end else if (acc) begin
                m_pend = 1; m_pend_rank = rank; m_pend_tgt = tgt;
            end
        end
    endtask

    task automatic idle(input logic st, input logic ack);
        step(1'b1, st, ack, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        int cnt_valid8;
        int cnt_req;
        logic [31:0] exp_mis;
        logic [31:0] bt, jt;

        // Reset, then sequential fetch with ack every cycle.
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b0, 1'b1);
        check_val("boot_no_req", {31'd0, o_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0, 1'b1);
            check_val("seq_addr",  o_addr,  32'(4 * i));
            check_val("seq_plus4", o_plus4, 32'(4 * i + 4));
        end

        // Fresh reset; ack at 0x8 with a 3-cycle stall.
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        cnt_valid8 = 0;
        cnt_req = 0;
        idle(1'b1, 1'b1);
        if (o_valid && o_pc == 32'h8) cnt_valid8++;
        for (int i = 0; i < 3; i++) begin
            idle((i < 2) ? 1'b1 : 1'b0, 1'b1);
            if (o_valid && o_pc == 32'h8) cnt_valid8++;
            if (o_req) cnt_req++;
        end
        check_val("hold_valid_cycles", 32'(cnt_valid8), 32'd4);
        check_val("hold_req_cycles",   32'(cnt_req),    32'd0);
        idle(1'b0, 1'b0);
        check_val("after_hold_addr", o_addr, 32'hC);

        // Branch to 0x40 while the 0x10 fetch is outstanding.
        idle(1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        check_val("br_flush", {31'd0, o_flush}, 32'd1);
        idle(1'b0, 1'b0);
        check_val("br_addr_stable", o_addr, 32'h10);
        idle(1'b0, 1'b1);
        check_val("br_discard", {31'd0, o_valid}, 32'd0);
        idle(1'b0, 1'b0);
        check_val("br_target_addr", o_addr, 32'h40);

        // Trap, branch and jump together: trap wins.
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h90);
        check_val("prio_flush", {31'd0, o_flush}, 32'd1);
        idle(1'b0, 1'b0);
        check_val("prio_addr", o_addr, 32'h100);

        // Sequential wrap at the top of the address space.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        idle(1'b0, 1'b1);
        check_val("wrap_plus4", o_plus4, 32'h0);
        idle(1'b0, 1'b0);
        check_val("wrap_addr", o_addr, 32'h0);

        // Misaligned jump target.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h42);
        idle(1'b0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
        exp_mis = 32'h100;
`else
        exp_mis = 32'h40;
`endif
        check_val("misalign_addr", o_addr, exp_mis);

        // Randomized traffic, including occasional mid-fetch resets.
        for (int i = 0; i < 2000; i++) begin
            bt = $urandom();
            jt = $urandom();
            if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) jt = jt & 32'hFFFF_FFFC;
            step(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, bt,
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, jt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
